subsample_8x8: RTL and testbench

- Chroma 4:2:0 down-sampler for the encode/verification path; the inverse of the decoder's 4x4-to-8x8 chroma supersampler.
- Accepts an 8x8 Cb or Cr block as a stream of eight row beats.
- Averages each 2x2 neighbourhood with rounding and emits one 4x4 block over a valid/ready handshake.
- A one-deep output register lets the next block's rows stream in while the current 4x4 result waits for the consumer.

---
 rtl/subsample_8x8_pkg.sv | 24 ++
 rtl/subsample_8x8_avg_2x2.sv | 23 ++
 rtl/sys_defs.svh | 7 +
 rtl/subsample_8x8.sv | 138 +++++++++++++
 tb/tb_subsample_8x8.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/subsample_8x8_pkg.sv
// Shared constants and types for the 8x8 -> 4x4 chroma down-sampler.
`include "sys_defs.svh"

package subsample_8x8_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned CH_W  = $clog2(`CH + 1);
    localparam int unsigned ACC_W = PIX_W + 2;

    localparam logic [CH_W-1:0] CH_Y  = CH_W'(0);
    localparam logic [CH_W-1:0] CH_CB = CH_W'(1);
    localparam logic [CH_W-1:0] CH_CR = CH_W'(2);

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [7:0]       row8_t;
    typedef pix_t [3:0][3:0]  blk4_t;
    typedef logic [ACC_W-1:0] acc_t;

    // Only chroma tags are subsampled; anything else is dropped.
    function automatic logic ch_legal(input logic [CH_W-1:0] ch);
        return (ch == CH_CB) || (ch == CH_CR);
    endfunction

endpackage

// File: rtl/subsample_8x8_avg_2x2.sv
// One column pair of the 2x2 averager: accumulate two pixels, round half up.
module avg_2x2 #(
    parameter int unsigned PIX_W = 8
) (
    input  logic [PIX_W+1:0] acc_i,
    input  logic [PIX_W-1:0] pix_a_i,
    input  logic [PIX_W-1:0] pix_b_i,
    output logic [PIX_W+1:0] acc_next_o,
    output logic [PIX_W-1:0] avg_o
);

    localparam int unsigned ACC_W = PIX_W + 2;

    logic [ACC_W-1:0] rnd;

    // Four pixels never exceed ACC_W bits, and (max + 2) >> 2 fits PIX_W.
    always_comb begin
        acc_next_o = acc_i + ACC_W'(pix_a_i) + ACC_W'(pix_b_i);
        rnd        = acc_next_o + ACC_W'(2);
        avg_o      = rnd[ACC_W-1:2];
    end

endmodule

// File: rtl/sys_defs.svh
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

// Highest channel tag value; channel fields are $clog2(`CH+1) bits wide.
`define CH 2

`endif

// File: rtl/subsample_8x8.sv
// 4:2:0 chroma down-sampler: eight row beats in, one rounded 4x4 block out.
module subsample_8x8 #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ROWS  = 8
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [subsample_8x8_pkg::CH_W-1:0]     ch_in,
    input  logic                                   valid_in,
    output logic                                   ready_in,
    input  logic [7:0][PIX_W-1:0]                  row_in,
    output logic                                   valid_out,
    input  logic                                   ready_out,
    output logic [3:0][3:0][PIX_W-1:0]             block_out,
    output logic [subsample_8x8_pkg::CH_W-1:0]     ch_out,
    output logic                                   err_ch
);

    import subsample_8x8_pkg::*;

    localparam int unsigned ACC_W    = PIX_W + 2;
    localparam int unsigned CNT_W    = $clog2(ROWS);
    localparam int unsigned COLS_OUT = 4;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    logic [CNT_W-1:0]                 row_cnt_q, row_cnt_d;
    logic [COLS_OUT-1:0][ACC_W-1:0]   acc_q, acc_d;
    logic [CH_W-1:0]                  ch_q, ch_d;
    logic [3:0][3:0][PIX_W-1:0]       stage_q, stage_d;
    logic [3:0][3:0][PIX_W-1:0]       blk_q, blk_d;
    logic [CH_W-1:0]                  ch_out_q, ch_out_d;
    logic                             valid_q, valid_d;
    logic                             err_q, err_d;

    logic [COLS_OUT-1:0][ACC_W-1:0]   acc_in;
    logic [COLS_OUT-1:0][ACC_W-1:0]   acc_nxt;
    logic [COLS_OUT-1:0][PIX_W-1:0]   avg_row;

    logic accept;
    logic odd_row;
    logic last_row;
    logic blk_legal;
    logic xfer;

    // Handshake decode; an illegal block never waits on the output register.
    always_comb begin
        odd_row   = row_cnt_q[0];
        last_row  = (row_cnt_q == LAST_ROW);
        blk_legal = ch_legal(ch_q);
        xfer      = valid_q && ready_out;
        ready_in  = !(last_row && blk_legal && valid_q && !ready_out);
        accept    = valid_in && ready_in;
    end

    // Even rows start a fresh column-pair sum, odd rows add onto it.
    always_comb begin
        for (int j = 0; j < COLS_OUT; j++) begin
            acc_in[j] = odd_row ? acc_q[j] : '0;
        end
    end

    for (genvar j = 0; j < COLS_OUT; j++) begin : g_avg
        avg_2x2 #(
            .PIX_W (PIX_W)
        ) u_avg (
            .acc_i      (acc_in[j]),
            .pix_a_i    (row_in[2*j]),
            .pix_b_i    (row_in[2*j+1]),
            .acc_next_o (acc_nxt[j]),
            .avg_o      (avg_row[j])
        );
    end

    // Next-state: row accumulation, staging, block load and output drain.
    always_comb begin
        row_cnt_d = row_cnt_q;
        acc_d     = acc_q;
        ch_d      = ch_q;
        stage_d   = stage_q;
        blk_d     = blk_q;
        ch_out_d  = ch_out_q;
        valid_d   = valid_q;
        err_d     = 1'b0;

        if (xfer) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + CNT_W'(1);
            acc_d     = acc_nxt;
            if (row_cnt_q == '0) begin
                ch_d = ch_in;
            end
            if (odd_row) begin
                stage_d[row_cnt_q[CNT_W-1:1]] = avg_row;
            end
            if (last_row) begin
                if (blk_legal) begin
                    blk_d    = stage_d;
                    ch_out_d = ch_q;
                    valid_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row_cnt_q <= '0;
            acc_q     <= '0;
            ch_q      <= '0;
            stage_q   <= '0;
            blk_q     <= '0;
            ch_out_q  <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            row_cnt_q <= row_cnt_d;
            acc_q     <= acc_d;
            ch_q      <= ch_d;
            stage_q   <= stage_d;
            blk_q     <= blk_d;
            ch_out_q  <= ch_out_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign valid_out = valid_q;
    assign block_out = blk_q;
    assign ch_out    = ch_out_q;
    assign err_ch    = err_q;

endmodule

// File: tb/tb_subsample_8x8.sv
// Directed bench for subsample_8x8: rounding, back-pressure, illegal channel, reset.
module tb_subsample_8x8;

    logic                   clock;
    logic                   reset_n;
    logic [1:0]             ch_in;
    logic                   valid_in;
    logic                   ready_in;
    logic [7:0][7:0]        row_in;
    logic                   valid_out;
    logic                   ready_out;
    logic [3:0][3:0][7:0]   block_out;
    logic [1:0]             ch_out;
    logic                   err_ch;

    int n_chk;
    int n_pass;

    logic [7:0][7:0][7:0]   img;
    logic [127:0]           exp_blk;

    subsample_8x8 #(
        .PIX_W (8),
        .ROWS  (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ch_in     (ch_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .row_in    (row_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .block_out (block_out),
        .ch_out    (ch_out),
        .err_ch    (err_ch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    task automatic fill_uniform(input logic [7:0] v);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = v;
    endtask

    function automatic logic [127:0] model(input logic [7:0][7:0][7:0] im);
        logic [3:0][3:0][7:0] b;
        int s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = int'(im[2*i][2*j]) + int'(im[2*i][2*j+1])
                  + int'(im[2*i+1][2*j]) + int'(im[2*i+1][2*j+1]);
                b[i][j] = 8'((s + 2) >> 2);
            end
        end
        return b;
    endfunction

    // Present one row and wait (bounded) until it is accepted.
    task automatic send_row(input logic [63:0] r, input logic [1:0] ch);
        int n;
        n = 0;
        valid_in = 1'b1;
        row_in   = r;
        ch_in    = ch;
        #1;
        while (!ready_in && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            $error("FAIL row_accept_timeout: observed stalled %0d cycles expected accept", n);
        end
        tick();
    endtask

    task automatic send_block(input logic [1:0] ch);
        for (int r = 0; r < 8; r++) send_row(img[r], ch);
        valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        row_in    = '0;
        ch_in     = 2'b00;
        img       = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // reset state
        check("rst_valid_out", 128'(valid_out), 128'd0);
        check("rst_ready_in",  128'(ready_in),  128'd1);
        check("rst_block_out", block_out,       128'd0);
        check("rst_ch_out",    128'(ch_out),    128'd0);
        check("rst_err_ch",    128'(err_ch),    128'd0);

        // uniform 0x80 Cb block
        ready_out = 1'b1;
        fill_uniform(8'h80);
        send_block(2'b01);
        check("uni_valid",  128'(valid_out), 128'd1);
        check("uni_block",  block_out,       {16{8'h80}});
        check("uni_ch",     128'(ch_out),    128'd1);
        check("uni_err",    128'(err_ch),    128'd0);
        tick();
        check("uni_valid_drop", 128'(valid_out), 128'd0);

        // rounding: {0,0,0,2} -> 1
        fill_uniform(8'h00);
        for (int r = 1; r < 8; r += 2)
            for (int c = 1; c < 8; c += 2)
                img[r][c] = 8'd2;
        send_block(2'b01);
        check("rnd2_valid", 128'(valid_out), 128'd1);
        check("rnd2_block", block_out,       {16{8'h01}});
        tick();

        // rounding: {0,0,0,1} -> 0
        for (int r = 1; r < 8; r += 2)
            for (int c = 1; c < 8; c += 2)
                img[r][c] = 8'd1;
        send_block(2'b01);
        check("rnd1_valid", 128'(valid_out), 128'd1);
        check("rnd1_block", block_out,       128'd0);
        tick();

        // all 255 -> 255, no overflow
        fill_uniform(8'hFF);
        send_block(2'b01);
        check("max_block", block_out, {16{8'hFF}});
        tick();

        // gradient Cr block: out[i][j] = 32i + 4j + 9
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'(16*r + 2*c);
        send_block(2'b10);
        check("grad_block", block_out, model(img));
        check("grad_00",    128'(block_out[0][0]), 128'd9);
        check("grad_12",    128'(block_out[1][2]), 128'd49);
        check("grad_33",    128'(block_out[3][3]), 128'd117);
        check("grad_ch",    128'(ch_out),          128'd2);
        tick();

        // back-pressure: first block held, second stalls at row 7
        ready_out = 1'b0;
        fill_uniform(8'h11);
        send_block(2'b01);
        check("bp_a_valid", 128'(valid_out), 128'd1);
        check("bp_a_block", block_out,       {16{8'h11}});
        fill_uniform(8'h22);
        for (int r = 0; r < 7; r++) send_row(img[r], 2'b10);
        valid_in = 1'b1;
        row_in   = img[7];
        #1;
        check("bp_row7_stall", 128'(ready_in), 128'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_block", block_out,        {16{8'h11}});
            check("bp_hold_ch",    128'(ch_out),     128'd1);
            check("bp_hold_ready", 128'(ready_in),   128'd0);
        end
        ready_out = 1'b1;
        #1;
        check("bp_release_ready", 128'(ready_in), 128'd1);
        tick();
        valid_in = 1'b0;
        check("bp_b_valid", 128'(valid_out), 128'd1);
        check("bp_b_block", block_out,       {16{8'h22}});
        check("bp_b_ch",    128'(ch_out),    128'd2);
        tick();
        check("bp_b_drain", 128'(valid_out), 128'd0);

        // illegal channel with empty output register
        fill_uniform(8'h33);
        send_block(2'b00);
        check("ill_err_pulse", 128'(err_ch),    128'd1);
        check("ill_no_valid",  128'(valid_out), 128'd0);
        check("ill_no_load",   block_out,       {16{8'h22}});
        tick();
        check("ill_err_clear", 128'(err_ch),    128'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'(20*r + 3*c);
        send_block(2'b01);
        check("post_ill_block", block_out,       model(img));
        check("post_ill_ch",    128'(ch_out),    128'd1);
        check("post_ill_valid", 128'(valid_out), 128'd1);
        tick();

        // illegal channel while a block is pending: row 7 is not stalled
        ready_out = 1'b0;
        fill_uniform(8'h44);
        send_block(2'b10);
        fill_uniform(8'h55);
        send_block(2'b11);
        check("ill_pend_err",   128'(err_ch),    128'd1);
        check("ill_pend_valid", 128'(valid_out), 128'd1);
        check("ill_pend_block", block_out,       {16{8'h44}});
        check("ill_pend_ch",    128'(ch_out),    128'd2);
        ready_out = 1'b1;
        tick();
        check("ill_pend_drain", 128'(valid_out), 128'd0);

        // reset after row 3 discards the partial block
        fill_uniform(8'hFF);
        for (int r = 0; r < 4; r++) send_row(img[r], 2'b01);
        valid_in = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check("mid_rst_valid", 128'(valid_out), 128'd0);
        check("mid_rst_ready", 128'(ready_in),  128'd1);
        check("mid_rst_block", block_out,       128'd0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 8'(5*(r + c));
        exp_blk = model(img);
        send_block(2'b10);
        check("fresh_valid", 128'(valid_out), 128'd1);
        check("fresh_block", block_out,       exp_blk);
        check("fresh_00",    128'(block_out[0][0]), 128'd5);
        check("fresh_ch",    128'(ch_out),    128'd2);
        tick();
        check("fresh_drain", 128'(valid_out), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
